// File: rtl/pgm_sched.sv
// pgm_sched: packet generator scheduler.
// Reads a packet template of L lines (L = LEN, 0 meaning 128) from a RAM,
// forwards each line downstream, marks the last line valid and repeats the
// packet COUNT times (0 = until aborted) with GAP idle cycles between packets.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cfg_wr/cfg_addr/cfg_wdata       config writes: 0=LEN 1=COUNT 2=GAP 3=CTRL
//                                   CTRL bit0 = START (IDLE only), bit1 = ABORT
//   rd2ram_rd/rd2ram_addr           template RAM read request
//   ram2rd_rdata                    RAM data, valid one cycle after the read
//   out_data/out_data_wr            generated line and its strobe
//   out_valid/out_valid_wr          end-of-packet flag and its strobe
//   in_alf                          downstream almost-full, checked before a packet
//   sent_start_flag                 run active
//   sent_finish_flag                one-cycle pulse at run end
//   sent_cnt                        packets sent in current/last run
//
// state | meaning
// IDLE  | configurable, waiting for START
// WAIT  | waiting for in_alf low before the next packet
// READ  | one template line read per cycle
// GAP   | inter-packet idle time, also drains the last RAM read
// DONE  | one-cycle finish pulse, back to IDLE
module pgm_sched (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_wr,
   input  logic [1:0]   cfg_addr,
   input  logic [31:0]  cfg_wdata,
   output logic         rd2ram_rd,
   output logic [6:0]   rd2ram_addr,
   input  logic [143:0] ram2rd_rdata,
   output logic [133:0] out_data,
   output logic         out_data_wr,
   output logic         out_valid,
   output logic         out_valid_wr,
   input  logic         in_alf,
   output logic         sent_start_flag,
   output logic         sent_finish_flag,
   output logic [31:0]  sent_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_READ,
      ST_GAP,
      ST_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [6:0]  len_q, len_d;
   logic [31:0] count_q, count_d;
   logic [15:0] gap_q, gap_d;
   logic        abort_q, abort_d;
   logic [6:0]  addr_q, addr_d;
   logic [15:0] gap_cnt_q, gap_cnt_d;
   logic [31:0] sent_cnt_q, sent_cnt_d;
   logic        dwr_q;
   logic        last_q;

   logic        wr_ctrl;
   logic        is_last;
   logic [15:0] gap_load;
   logic        unused_rdata_hi;

   assign wr_ctrl  = cfg_wr && (cfg_addr == 2'd3);
   // len_q - 1 wraps to 127 when LEN=0, giving the 128-line packet.
   assign is_last  = (addr_q == len_q - 7'd1);
   // GAP of 0 still takes one cycle so the last RAM read can drain.
   assign gap_load = (gap_q == 16'd0) ? 16'd0 : gap_q - 16'd1;
   assign unused_rdata_hi = ^ram2rd_rdata[143:134];

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      count_d    = count_q;
      gap_d      = gap_q;
      abort_d    = abort_q;
      addr_d     = addr_q;
      gap_cnt_d  = gap_cnt_q;
      sent_cnt_d = sent_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_wr) begin
               case (cfg_addr)
                  2'd0: len_d   = cfg_wdata[6:0];
                  2'd1: count_d = cfg_wdata;
                  2'd2: gap_d   = cfg_wdata[15:0];
                  default: begin
                     if (cfg_wdata[0]) begin
                        state_d    = ST_WAIT;
                        sent_cnt_d = 32'd0;
                     end
                  end
               endcase
            end
         end
         ST_WAIT: begin
            if (abort_q) begin
               state_d = ST_DONE;
            end else if (!in_alf) begin
               state_d = ST_READ;
               addr_d  = 7'd0;
            end
         end
         ST_READ: begin
            if (is_last) begin
               state_d    = ST_GAP;
               addr_d     = 7'd0;
               gap_cnt_d  = gap_load;
               sent_cnt_d = sent_cnt_q + 32'd1;
            end else begin
               addr_d = addr_q + 7'd1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == 16'd0) begin
               if (abort_q || ((count_q != 32'd0) && (sent_cnt_q == count_q))) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - 16'd1;
            end
         end
         ST_DONE: begin
            abort_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // ABORT only latches during an active run; DONE clears it instead.
      if (wr_ctrl && cfg_wdata[1] &&
          (state_q == ST_WAIT || state_q == ST_READ || state_q == ST_GAP)) begin
         abort_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= 7'd0;
         count_q    <= 32'd0;
         gap_q      <= 16'd0;
         abort_q    <= 1'b0;
         addr_q     <= 7'd0;
         gap_cnt_q  <= 16'd0;
         sent_cnt_q <= 32'd0;
         dwr_q      <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         count_q    <= count_d;
         gap_q      <= gap_d;
         abort_q    <= abort_d;
         addr_q     <= addr_d;
         gap_cnt_q  <= gap_cnt_d;
         sent_cnt_q <= sent_cnt_d;
         dwr_q      <= (state_q == ST_READ);
         last_q     <= (state_q == ST_READ) && is_last;
      end
   end

   assign rd2ram_rd        = (state_q == ST_READ);
   assign rd2ram_addr      = addr_q;
   // RAM data arrives combinationally one cycle after the read; gating keeps
   // out_data at zero outside the strobe and during reset.
   assign out_data         = dwr_q ? ram2rd_rdata[133:0] : 134'd0;
   assign out_data_wr      = dwr_q;
   assign out_valid        = last_q;
   assign out_valid_wr     = last_q;
   assign sent_start_flag  = (state_q == ST_WAIT) || (state_q == ST_READ) || (state_q == ST_GAP);
   assign sent_finish_flag = (state_q == ST_DONE);
   assign sent_cnt         = sent_cnt_q;

endmodule

// File: tb/tb_pgm_sched.sv
module tb_pgm_sched;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_wr = 1'b0;
   logic [1:0]   cfg_addr = 2'd0;
   logic [31:0]  cfg_wdata = 32'd0;
   logic         rd2ram_rd;
   logic [6:0]   rd2ram_addr;
   logic [143:0] ram2rd_rdata = '0;
   logic [133:0] out_data;
   logic         out_data_wr;
   logic         out_valid;
   logic         out_valid_wr;
   logic         in_alf = 1'b0;
   logic         sent_start_flag;
   logic         sent_finish_flag;
   logic [31:0]  sent_cnt;

   always #5 clk = ~clk;

   pgm_sched dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cfg_wr           (cfg_wr),
      .cfg_addr         (cfg_addr),
      .cfg_wdata        (cfg_wdata),
      .rd2ram_rd        (rd2ram_rd),
      .rd2ram_addr      (rd2ram_addr),
      .ram2rd_rdata     (ram2rd_rdata),
      .out_data         (out_data),
      .out_data_wr      (out_data_wr),
      .out_valid        (out_valid),
      .out_valid_wr     (out_valid_wr),
      .in_alf           (in_alf),
      .sent_start_flag  (sent_start_flag),
      .sent_finish_flag (sent_finish_flag),
      .sent_cnt         (sent_cnt)
   );

   // template RAM with one cycle read latency
   logic [143:0] mem [128];
   always @(posedge clk) if (rd2ram_rd) ram2rd_rdata <= mem[rd2ram_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [133:0] data;
      bit           last;
      int           cnt;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   int n_vec = 0;
   int n_err = 0;

   int rd_cycs[$];
   int first_wr_cyc = -1;
   int valid_cyc = -1;
   int fin_cyc = -1;
   int fin_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_data(input string name, input logic [133:0] act, input logic [133:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor / scoreboard checker
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd2ram_rd) rd_cycs.push_back(cyc);
         if (out_data_wr) begin
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_line: got out_data_wr with data %h, expected none (cycle %0d)", out_data, cyc);
            end else begin
               mon_e = sb.pop_front();
               chk_data("out_data", out_data, mon_e.data);
               chk("out_valid_wr", int'(out_valid_wr), int'(mon_e.last));
               chk("out_valid", int'(out_valid), int'(mon_e.last));
               if (mon_e.last) chk("sent_cnt_at_valid", int'(sent_cnt), mon_e.cnt);
            end
         end else if (out_valid_wr) begin
            chk("valid_wr_without_data", int'(out_valid_wr), 0);
         end
         if (out_valid_wr) valid_cyc = cyc;
         if (sent_finish_flag) begin
            fin_total++;
            fin_cyc = cyc;
         end
      end
   end

   // reference: L lines per packet from template lines 0..L-1, last one valid
   task automatic push_pkts(input int len, input int npk);
      exp_t e;
      for (int p = 0; p < npk; p++) begin
         for (int i = 0; i < len; i++) begin
            e.data = mem[i][133:0];
            e.last = (i == len - 1);
            e.cnt  = p + 1;
            sb.push_back(e);
         end
      end
   endtask

   task automatic cfg(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(posedge clk); #1;
      cfg_wr = 1'b0;
   endtask

   task automatic setup(input int len, input int count, input int gap);
      cfg(2'd0, 32'(len));
      cfg(2'd1, 32'(count));
      cfg(2'd2, 32'(gap));
   endtask

   task automatic start_run(input logic [31:0] ctrl, output int t);
      rd_cycs.delete();
      first_wr_cyc = -1;
      valid_cyc = -1;
      fin_cyc = -1;
      cfg(2'd3, ctrl);
      t = cyc;
   endtask

   task automatic wait_fin(input int budget, input bit rand_alf, output int nfin);
      int fin0;
      int n;
      fin0 = fin_total;
      n = 0;
      while (fin_total == fin0 && n < budget) begin
         @(posedge clk); #1;
         if (rand_alf) in_alf = 1'($urandom_range(0, 1));
         n++;
      end
      in_alf = 1'b0;
      if (fin_total == fin0) begin
         n_vec++;
         n_err++;
         $display("FAIL finish_timeout: no sent_finish_flag within %0d cycles", budget);
      end
      repeat (4) @(posedge clk);
      #1;
      nfin = fin_total - fin0;
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rd"}, int'(rd2ram_rd), 0);
      chk({tag, "_addr"}, int'(rd2ram_addr), 0);
      chk_data({tag, "_out_data"}, out_data, '0);
      chk({tag, "_data_wr"}, int'(out_data_wr), 0);
      chk({tag, "_valid"}, int'(out_valid), 0);
      chk({tag, "_valid_wr"}, int'(out_valid_wr), 0);
      chk({tag, "_start_flag"}, int'(sent_start_flag), 0);
      chk({tag, "_finish_flag"}, int'(sent_finish_flag), 0);
      chk({tag, "_sent_cnt"}, int'(sent_cnt), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, nfin, g, gg, per, k, e_cyc, n, L, c;

      for (int i = 0; i < 128; i++) begin
         mem[i][31:0]    = $urandom;
         mem[i][63:32]   = $urandom;
         mem[i][95:64]   = $urandom;
         mem[i][127:96]  = $urandom;
         mem[i][143:128] = 16'($urandom);
      end

      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;

      // single packet, exact latency
      setup(4, 1, 0);
      push_pkts(4, 1);
      start_run(32'd1, t);
      wait_fin(100, 1'b0, nfin);
      chk("single_finish_pulses", nfin, 1);
      chk("single_rd_lines", rd_cycs.size(), 4);
      if (rd_cycs.size() > 0) chk("single_first_rd_cyc", rd_cycs[0], t + 1);
      chk("single_first_wr_cyc", first_wr_cyc, t + 2);
      chk("single_valid_cyc", valid_cyc, t + 5);
      chk("single_finish_cyc", fin_cyc, t + 6);
      chk("single_sent_cnt", int'(sent_cnt), 1);
      chk("single_start_flag_after", int'(sent_start_flag), 0);

      // three packets with GAP=5: 5 gap cycles plus the WAIT check between bursts
      setup(2, 3, 5);
      push_pkts(2, 3);
      start_run(32'd1, t);
      wait_fin(300, 1'b0, nfin);
      chk("multi_finish_pulses", nfin, 1);
      chk("multi_rd_lines", rd_cycs.size(), 6);
      if (rd_cycs.size() == 6) begin
         chk("multi_spacing_1", rd_cycs[2] - rd_cycs[1], 7);
         chk("multi_spacing_2", rd_cycs[4] - rd_cycs[3], 7);
      end
      chk("multi_sent_cnt", int'(sent_cnt), 3);

      // START and ABORT in one IDLE write: the abort is dropped
      setup(2, 2, 0);
      push_pkts(2, 2);
      start_run(32'd3, t);
      wait_fin(200, 1'b0, nfin);
      chk("start_abort_sent_cnt", int'(sent_cnt), 2);

      // backpressure in WAIT and during READ
      setup(5, 2, 1);
      push_pkts(5, 2);
      in_alf = 1'b1;
      start_run(32'd1, t);
      repeat (10) @(posedge clk);
      #1;
      chk("alf_no_reads", rd_cycs.size(), 0);
      in_alf = 1'b0;
      n = 0;
      while (rd_cycs.size() == 0 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      in_alf = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("alf_packet_completes", rd_cycs.size(), 5);
      in_alf = 1'b0;
      wait_fin(200, 1'b0, nfin);
      chk("alf_sent_cnt", int'(sent_cnt), 2);
      chk("alf_rd_lines", rd_cycs.size(), 10);

      // continuous run, abort in the middle of packet k
      g = $urandom_range(0, 3);
      gg = (g == 0) ? 1 : g;
      per = 3 + gg + 1;
      k = $urandom_range(1, 3);
      setup(3, 0, g);
      push_pkts(3, k + 1);
      start_run(32'd1, t);
      e_cyc = t + 2 + k * per;
      while (cyc < e_cyc - 1) begin
         @(posedge clk); #1;
      end
      cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'd2;
      @(posedge clk); #1;
      cfg_wr = 1'b0;
      wait_fin(300, 1'b0, nfin);
      chk("abort_finish_pulses", nfin, 1);
      chk("abort_sent_cnt", int'(sent_cnt), k + 1);
      chk("abort_rd_lines", rd_cycs.size(), 3 * (k + 1));

      // LEN=0 gives 128 lines; busy writes must not change the setup
      setup(0, 1, 0);
      push_pkts(128, 1);
      start_run(32'd1, t);
      cfg(2'd0, 32'd7);
      cfg(2'd1, 32'd9);
      cfg(2'd2, 32'd3);
      cfg(2'd3, 32'd1);
      wait_fin(400, 1'b0, nfin);
      chk("len0_rd_lines", rd_cycs.size(), 128);
      chk("len0_sent_cnt", int'(sent_cnt), 1);
      push_pkts(128, 1);
      start_run(32'd1, t);
      wait_fin(400, 1'b0, nfin);
      chk("busywr_rd_lines", rd_cycs.size(), 128);
      chk("busywr_finish_cyc", fin_cyc, t + 130);
      chk("busywr_sent_cnt", int'(sent_cnt), 1);

      // randomized runs with random backpressure
      for (int r = 0; r < 4; r++) begin
         L = $urandom_range(1, 10);
         c = $urandom_range(1, 3);
         g = $urandom_range(0, 3);
         setup(L, c, g);
         push_pkts(L, c);
         start_run(32'd1, t);
         wait_fin(2000, 1'b1, nfin);
         chk("rand_finish_pulses", nfin, 1);
         chk("rand_sent_cnt", int'(sent_cnt), c);
         chk("rand_rd_lines", rd_cycs.size(), L * c);
      end

      // reset in the middle of READ
      setup(20, 1, 0);
      push_pkts(20, 1);
      start_run(32'd1, t);
      n = 0;
      while (rd_cycs.size() < 5 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      sb.delete();
      n = fin_total;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("midreset_no_finish", fin_total - n, 0);
      chk("midreset_start_flag", int'(sent_start_flag), 0);
      setup(2, 1, 0);
      push_pkts(2, 1);
      start_run(32'd1, t);
      wait_fin(100, 1'b0, nfin);
      chk("recover_sent_cnt", int'(sent_cnt), 1);
      chk("recover_rd_lines", rd_cycs.size(), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
